// File: rtl/alu_determinant_seq_if.sv
// Start/busy/done handshake and data bundle for alu_determinant_seq.
// master drives start/size/A_flat; slave returns busy/done/det_out/C_flat/flags.
interface alu_determinant_seq_if #(
   parameter int N      = 5,
   parameter int DATA_W = 8,
   parameter int ACC_W  = 48
);
   logic                      start;
   logic [3:0]                size;
   logic [N*N*DATA_W-1:0]     A_flat;
   logic                      busy;
   logic                      done;
   logic signed [ACC_W-1:0]   det_out;
   logic [N*N*DATA_W-1:0]     C_flat;
   logic                      overflow_flag;
   logic                      size_err;

   modport master (
      output start, size, A_flat,
      input  busy, done, det_out, C_flat, overflow_flag, size_err
   );

   modport slave (
      input  start, size, A_flat,
      output busy, done, det_out, C_flat, overflow_flag, size_err
   );
endinterface

// File: rtl/alu_determinant_seq.sv
// Sequential exact determinant (Bareiss, one element update per clock).
// Ports: clk, rst_n (sync, active-low), bus (alu_determinant_seq_if.slave).
// Build option: DET_PIVOT_EN adds SCAN/SWAP row pivoting on zero pivots.
module alu_determinant_seq #(
   parameter int N      = 5,
   parameter int DATA_W = 8,
   parameter int ACC_W  = 48
) (
   input  logic                 clk,
   input  logic                 rst_n,
   alu_determinant_seq_if.slave bus
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int CW = N*N*DATA_W;
   localparam logic signed [ACC_W-1:0] C_MAX =
      ACC_W'((64'sd1 <<< (DATA_W-1)) - 64'sd1);
   localparam logic signed [ACC_W-1:0] C_MIN = ~C_MAX;

   typedef enum logic [2:0] {
      S_IDLE, S_PIVOT, S_SCAN, S_SWAP, S_ELIM, S_FINISH
   } state_t;

   state_t                  r_state;
   logic signed [ACC_W-1:0] r_m [N][N];
   logic [IW-1:0]           r_k;
   logic [IW-1:0]           r_i;
   logic [IW-1:0]           r_j;
   logic [IW-1:0]           r_nm1;
`ifdef DET_PIVOT_EN
   logic [IW-1:0]           r_r;
`endif
   logic signed [ACC_W-1:0] r_prev;
   logic                    r_neg;
   logic                    r_zero;
   logic                    r_busy;
   logic                    r_done;
   logic signed [ACC_W-1:0] r_det;
   logic [CW-1:0]           r_c;
   logic                    r_ovf;
   logic                    r_serr;

   logic signed [ACC_W-1:0]   w_mkk, w_mij, w_mik, w_mkj, w_last;
   logic signed [2*ACC_W-1:0] w_a, w_b, w_c, w_d, w_num, w_den;
   logic signed [ACC_W-1:0]   w_q, w_det;
   logic                      w_ovf;

   assign w_mkk  = r_m[r_k][r_k];
   assign w_mij  = r_m[r_i][r_j];
   assign w_mik  = r_m[r_i][r_k];
   assign w_mkj  = r_m[r_k][r_j];
   assign w_last = r_m[r_nm1][r_nm1];

   // Double-width products keep the Bareiss numerator exact.
   assign w_a   = {{ACC_W{w_mij[ACC_W-1]}}, w_mij};
   assign w_b   = {{ACC_W{w_mkk[ACC_W-1]}}, w_mkk};
   assign w_c   = {{ACC_W{w_mik[ACC_W-1]}}, w_mik};
   assign w_d   = {{ACC_W{w_mkj[ACC_W-1]}}, w_mkj};
   assign w_den = {{ACC_W{r_prev[ACC_W-1]}}, r_prev};
   assign w_num = w_a * w_b - w_c * w_d;
   // prev is never zero: it starts at 1 and only takes nonzero pivots.
   assign w_q   = ACC_W'(w_num / w_den);

   assign w_det = r_zero ? '0 : (r_neg ? -w_last : w_last);
   assign w_ovf = (w_det > C_MAX) || (w_det < C_MIN);

   assign bus.busy          = r_busy;
   assign bus.done          = r_done;
   assign bus.det_out       = r_det;
   assign bus.C_flat        = r_c;
   assign bus.overflow_flag = r_ovf;
   assign bus.size_err      = r_serr;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_k     <= '0;
         r_i     <= '0;
         r_j     <= '0;
         r_nm1   <= '0;
`ifdef DET_PIVOT_EN
         r_r     <= '0;
`endif
         r_prev  <= ACC_W'(1);
         r_neg   <= 1'b0;
         r_zero  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_det   <= '0;
         r_c     <= '0;
         r_ovf   <= 1'b0;
         r_serr  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  for (int i = 0; i < N; i++)
                     for (int j = 0; j < N; j++)
                        r_m[i][j] <= (i < int'(bus.size) && j < int'(bus.size))
                           ? ACC_W'(signed'(bus.A_flat[(i*N+j)*DATA_W +: DATA_W]))
                           : '0;
                  r_busy <= 1'b1;
                  r_det  <= '0;
                  r_c    <= '0;
                  r_ovf  <= 1'b0;
                  r_k    <= '0;
                  r_prev <= ACC_W'(1);
                  r_neg  <= 1'b0;
                  if (bus.size == 4'd0 || int'(bus.size) > N) begin
                     r_serr  <= 1'b1;
                     r_zero  <= 1'b1;
                     r_nm1   <= '0;
                     r_state <= S_FINISH;
                  end else begin
                     r_serr  <= 1'b0;
                     r_zero  <= 1'b0;
                     r_nm1   <= IW'(bus.size - 4'd1);
                     r_state <= (bus.size == 4'd1) ? S_FINISH : S_PIVOT;
                  end
               end
            end
            S_PIVOT: begin
               if (w_mkk != '0) begin
                  r_i     <= r_k + 1'b1;
                  r_j     <= r_k + 1'b1;
                  r_state <= S_ELIM;
               end else begin
`ifdef DET_PIVOT_EN
                  r_r     <= r_k + 1'b1;
                  r_state <= S_SCAN;
`else
                  r_zero  <= 1'b1;
                  r_state <= S_FINISH;
`endif
               end
            end
`ifdef DET_PIVOT_EN
            S_SCAN: begin
               if (r_m[r_r][r_k] != '0) begin
                  r_state <= S_SWAP;
               end else if (r_r == r_nm1) begin
                  r_zero  <= 1'b1;
                  r_state <= S_FINISH;
               end else begin
                  r_r <= r_r + 1'b1;
               end
            end
            S_SWAP: begin
               // Columns left of k are dead; swapping whole rows is equivalent.
               for (int j = 0; j < N; j++) begin
                  r_m[r_k][j] <= r_m[r_r][j];
                  r_m[r_r][j] <= r_m[r_k][j];
               end
               r_neg   <= ~r_neg;
               r_i     <= r_k + 1'b1;
               r_j     <= r_k + 1'b1;
               r_state <= S_ELIM;
            end
`endif
            S_ELIM: begin
               r_m[r_i][r_j] <= w_q;
               if (r_j == r_nm1) begin
                  if (r_i == r_nm1) begin
                     r_prev  <= w_mkk;
                     r_k     <= r_k + 1'b1;
                     r_state <= (r_k + 1'b1 == r_nm1) ? S_FINISH : S_PIVOT;
                  end else begin
                     r_i <= r_i + 1'b1;
                     r_j <= r_k + 1'b1;
                  end
               end else begin
                  r_j <= r_j + 1'b1;
               end
            end
            S_FINISH: begin
               r_det   <= w_det;
               r_c     <= CW'(w_det[DATA_W-1:0]);
               r_ovf   <= w_ovf;
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_determinant_seq.sv
// Directed-vector bench for alu_determinant_seq.
// Hand-computed determinants, latencies, flags and reset behaviour.
module tb_alu_determinant_seq;
   localparam int N  = 5;
   localparam int DW = 8;
   localparam int AW = 48;
   localparam int CW = N*N*DW;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int failures = 0;
   logic [CW-1:0] a;
   logic [CW-1:0] expc;

   alu_determinant_seq_if #(.N(N), .DATA_W(DW), .ACC_W(AW)) bus ();

   alu_determinant_seq #(.N(N), .DATA_W(DW), .ACC_W(AW)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   function automatic longint det_s();
      return longint'($signed(bus.det_out));
   endfunction

   task automatic set_a(input int i, input int j, input int v);
      a[(i*N+j)*DW +: DW] = DW'(v);
   endtask

   task automatic set_ident();
      a = '0;
      for (int i = 0; i < N; i++) set_a(i, i, 1);
   endtask

   // Pulses start, returns latency (inclusive edge count) or -1 on timeout.
   task automatic run(input logic [3:0] sz, output int lat);
      bus.size = sz;
      bus.A_flat = a;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      lat = 1;
      while (!bus.done && lat < 300) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!bus.done) lat = -1;
   endtask

   task automatic test_reset();
      bus.start = 1'b0; bus.size = '0; bus.A_flat = '0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({bus.busy, bus.done, bus.overflow_flag, bus.size_err} !== 4'b0) begin
         failures++;
         $display("FAIL rst_flags got %b want 0000",
                  {bus.busy, bus.done, bus.overflow_flag, bus.size_err});
      end
      checks++;
      if (bus.det_out !== '0 || bus.C_flat !== '0) begin
         failures++; $display("FAIL rst_data got det=%0d want 0", det_s());
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_identity();
      int lat;
      set_ident();
      run(4'd5, lat);
      expc = '0; expc[7:0] = 8'h01;
      checks++;
      if (lat !== 36) begin failures++; $display("FAIL id_lat got %0d want 36", lat); end
      checks++;
      if (det_s() !== 64'sd1) begin failures++; $display("FAIL id_det got %0d want 1", det_s()); end
      checks++;
      if (bus.C_flat !== expc) begin failures++; $display("FAIL id_cflat got %h want %h", bus.C_flat[15:0], expc[15:0]); end
      checks++;
      if (bus.overflow_flag !== 1'b0 || bus.busy !== 1'b0) begin
         failures++; $display("FAIL id_ovf_busy got %b%b want 00", bus.overflow_flag, bus.busy);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.done !== 1'b0) begin failures++; $display("FAIL id_done_pulse got 1 want 0"); end
   endtask

   task automatic test_pivot();
      int lat;
      a = '0;
      set_a(0, 0, 0); set_a(0, 1, 3);
      set_a(1, 0, 2); set_a(1, 1, 5);
      run(4'd2, lat);
`ifdef DET_PIVOT_EN
      expc = '0; expc[7:0] = 8'hFA;
      checks++;
      if (det_s() !== -64'sd6) begin failures++; $display("FAIL piv_det got %0d want -6", det_s()); end
      checks++;
      if (bus.C_flat !== expc) begin failures++; $display("FAIL piv_cflat got %h want fa", bus.C_flat[7:0]); end
      checks++;
      if (lat !== 6) begin failures++; $display("FAIL piv_lat got %0d want 6", lat); end
`else
      checks++;
      if (det_s() !== 64'sd0) begin failures++; $display("FAIL piv_det got %0d want 0", det_s()); end
      checks++;
      if (lat !== 3) begin failures++; $display("FAIL piv_lat got %0d want 3", lat); end
`endif
   endtask

   task automatic test_diag_ovf();
      int lat;
      a = '0;
      set_a(0, 0, 10); set_a(1, 1, 10); set_a(2, 2, 10);
      set_a(3, 3, 1); set_a(4, 4, 1);
      run(4'd5, lat);
      expc = '0; expc[7:0] = 8'hE8;
      checks++;
      if (det_s() !== 64'sd1000) begin failures++; $display("FAIL dg_det got %0d want 1000", det_s()); end
      checks++;
      if (bus.C_flat !== expc) begin failures++; $display("FAIL dg_cflat got %h want e8", bus.C_flat[7:0]); end
      checks++;
      if (bus.overflow_flag !== 1'b1) begin failures++; $display("FAIL dg_ovf got 0 want 1"); end
      checks++;
      if (lat !== 36) begin failures++; $display("FAIL dg_lat got %0d want 36", lat); end
   endtask

   task automatic test_neg_ovf();
      int lat;
      a = '0;
      for (int i = 0; i < N; i++) set_a(i, i, -128);
      run(4'd5, lat);
      checks++;
      if (det_s() !== -64'sd34359738368) begin
         failures++; $display("FAIL neg_det got %0d want -34359738368", det_s());
      end
      checks++;
      if (bus.overflow_flag !== 1'b1) begin failures++; $display("FAIL neg_ovf got 0 want 1"); end
   endtask

   task automatic test_singular();
      int lat;
      int r1 [5] = '{1, 2, 0, 0, 1};
      int r2 [5] = '{0, 1, 1, 0, 0};
      int r3 [5] = '{2, 0, 1, 1, 0};
      int r5 [5] = '{1, 0, 0, 0, 1};
      a = '0;
      for (int j = 0; j < N; j++) begin
         set_a(0, j, r1[j]); set_a(1, j, r2[j]); set_a(2, j, r3[j]);
         set_a(3, j, r2[j]); set_a(4, j, r5[j]);
      end
      run(4'd5, lat);
      checks++;
      if (lat < 0) begin failures++; $display("FAIL sg_timeout got none want done"); end
      checks++;
      if (det_s() !== 64'sd0 || bus.overflow_flag !== 1'b0) begin
         failures++; $display("FAIL sg_det got %0d/%b want 0/0", det_s(), bus.overflow_flag);
      end
   endtask

   task automatic set_3x3();
      a = '0;
      set_a(0, 0, 2); set_a(0, 1, 1); set_a(0, 2, 0);
      set_a(1, 0, 1); set_a(1, 1, 3); set_a(1, 2, 1);
      set_a(2, 0, 0); set_a(2, 1, 1); set_a(2, 2, 4);
   endtask

   task automatic test_3x3_ignore();
      int lat;
      set_3x3();
      bus.size = 4'd3; bus.A_flat = a; bus.start = 1'b1;
      @(posedge clk); #1;
      lat = 1;
      while (!bus.done && lat < 300) begin
         if (lat == 4) begin
            bus.start = 1'b1; bus.size = 4'd5; set_ident(); bus.A_flat = a;
         end else begin
            bus.start = 1'b0;
         end
         @(posedge clk); #1;
         lat++;
      end
      bus.start = 1'b0;
      checks++;
      if (lat !== 9) begin failures++; $display("FAIL x3_lat got %0d want 9", lat); end
      checks++;
      if (det_s() !== 64'sd18) begin failures++; $display("FAIL x3_det got %0d want 18", det_s()); end
   endtask

   task automatic test_back_to_back();
      int lat;
      set_3x3();
      run(4'd3, lat);
      checks++;
      if (det_s() !== 64'sd18) begin failures++; $display("FAIL b2b_first got %0d want 18", det_s()); end
      a = '0;
      set_a(0, 0, 3); set_a(0, 1, 1);
      set_a(1, 0, 2); set_a(1, 1, 4);
      run(4'd2, lat);
      checks++;
      if (lat !== 4) begin failures++; $display("FAIL b2b_lat got %0d want 4", lat); end
      checks++;
      if (det_s() !== 64'sd10) begin failures++; $display("FAIL b2b_det got %0d want 10", det_s()); end
   endtask

   task automatic test_size0();
      int lat;
      set_ident();
      run(4'd0, lat);
      checks++;
      if (bus.size_err !== 1'b1) begin failures++; $display("FAIL s0_err got 0 want 1"); end
      checks++;
      if (det_s() !== 64'sd0) begin failures++; $display("FAIL s0_det got %0d want 0", det_s()); end
      checks++;
      if (lat !== 2) begin failures++; $display("FAIL s0_lat got %0d want 2", lat); end
   endtask

   task automatic test_size1();
      int lat;
      a = '0;
      set_a(0, 0, -7); set_a(1, 1, 9);
      run(4'd1, lat);
      checks++;
      if (det_s() !== -64'sd7) begin failures++; $display("FAIL s1_det got %0d want -7", det_s()); end
      checks++;
      if (bus.size_err !== 1'b0 || bus.overflow_flag !== 1'b0) begin
         failures++; $display("FAIL s1_flags got %b%b want 00", bus.size_err, bus.overflow_flag);
      end
      checks++;
      if (bus.C_flat[7:0] !== 8'hF9) begin failures++; $display("FAIL s1_cflat got %h want f9", bus.C_flat[7:0]); end
   endtask

   task automatic test_midop_reset();
      int seen;
      set_ident();
      bus.size = 4'd5; bus.A_flat = a; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (8) begin @(posedge clk); #1; end
      checks++;
      if (bus.busy !== 1'b1) begin failures++; $display("FAIL mr_busy got 0 want 1"); end
      rst_n = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({bus.busy, bus.done, bus.overflow_flag, bus.size_err} !== 4'b0
          || bus.det_out !== '0 || bus.C_flat !== '0) begin
         failures++; $display("FAIL mr_clear got det=%0d busy=%b want 0", det_s(), bus.busy);
      end
      rst_n = 1'b1;
      seen = 0;
      repeat (50) begin
         @(posedge clk); #1;
         if (bus.done) seen++;
      end
      checks++;
      if (seen !== 0) begin failures++; $display("FAIL mr_nodone got %0d want 0", seen); end
   endtask

   initial begin
      test_reset();
      test_identity();
      test_pivot();
      test_diag_ovf();
      test_neg_ovf();
      test_singular();
      test_3x3_ignore();
      test_back_to_back();
      test_size0();
      test_size1();
      test_midop_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
